// File: rtl/down_timer.sv
// down_timer: loadable down-counter with one-shot or periodic (auto-reload) mode.
// Latency: start at edge 0 with count=L gives the first decrement at edge 1 and the terminal count at edge L.
// Backpressure: none; stop pauses the countdown and load aborts it.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst          asynchronous, active-high reset
//   load         captures load_value into count and the reload register; highest priority
//   load_value   value for count and the reload register (WIDTH bits)
//   start        begins a countdown from IDLE/PAUSE, or restarts it from DONE
//   stop         pauses a running countdown; beats start when both are high
//   auto_reload  1 = periodic, 0 = one-shot; sampled live on every terminal count
//   prescale     (only with DOWN_TIMER_PRESCALE_EN) decrement period minus one, sampled live
//   count        current remaining count (registered)
//   busy         high while the FSM is in RUN
//   done         high while the FSM is in DONE
//   tc           one-cycle terminal-count pulse (registered)
//
// Optional feature: define DOWN_TIMER_PRESCALE_EN to add the 4-bit prescale input and the
// internal prescaler. Without it the count steps on every RUN cycle.

module down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
`ifdef DOWN_TIMER_PRESCALE_EN
    input  logic [3:0]       prescale,
`endif
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] reload;
    logic             tick;

    // Reaching the terminal count on this tick. count is never 0 in RUN, so
    // "not greater than one" is the count==1 case; the <=1 form keeps a stray
    // 0 from ever being decremented into all-ones.
    logic at_terminal;
    assign at_terminal = (count <= WIDTH'(1));

    // Periodic reload only makes sense with a non-zero reload value; a zero
    // reload would otherwise leave RUN showing count=0 forever.
    logic do_reload;
    assign do_reload = auto_reload && (reload != '0);

`ifdef DOWN_TIMER_PRESCALE_EN
    logic [3:0] prescaler;

    assign tick = (prescaler == prescale);

    // The prescaler is only live inside RUN. Holding it at zero everywhere
    // else means entering RUN always starts a fresh period; it is also
    // cleared on every exit from RUN (load, stop, one-shot terminal count).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= 4'd0;
        end else if (load || state != RUN || stop) begin
            prescaler <= 4'd0;
        end else if (tick) begin
            prescaler <= 4'd0;
        end else begin
            prescaler <= prescaler + 4'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Single FSM block: busy/done are registered alongside every state change
    // so they are exact decodes of the state with no combinational path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            reload <= '0;
            tc     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            // tc is a pulse: only the terminal-count branch raises it.
            tc <= 1'b0;

            if (load) begin
                count  <= load_value;
                reload <= load_value;
                state  <= IDLE;
                busy   <= 1'b0;
                done   <= 1'b0;
            end else begin
                case (state)
                    RUN: begin
                        if (stop) begin
                            // Pause: count holds where it is.
                            state <= PAUSE;
                            busy  <= 1'b0;
                        end else if (tick) begin
                            if (!at_terminal) begin
                                count <= count - WIDTH'(1);
                            end else if (do_reload) begin
                                // Periodic: jump straight to the reload value
                                // so count never shows zero.
                                count <= reload;
                                tc    <= 1'b1;
                            end else begin
                                count <= '0;
                                tc    <= 1'b1;
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end

                    IDLE, PAUSE: begin
                        // A zero count has nothing to count down; ignore start.
                        if (!stop && start && count != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end

                    DONE: begin
                        // Restart from the last loaded value.
                        if (!stop && start && reload != '0) begin
                            count <= reload;
                            state <= RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end

                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer (WIDTH=8).
// Inputs change 1 time unit after a rising edge; outputs are sampled at that
// same point, so each sample reflects the edge just taken.

module tb_down_timer;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] load_value;
    logic       start;
    logic       stop;
    logic       auto_reload;
`ifdef DOWN_TIMER_PRESCALE_EN
    logic [3:0] prescale;
`endif
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic       tc;

    int tests_run;
    int tests_failed;

    down_timer #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .load_value  (load_value),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
`ifdef DOWN_TIMER_PRESCALE_EN
        .prescale    (prescale),
`endif
        .count       (count),
        .busy        (busy),
        .done        (done),
        .tc          (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load a value (one edge), leaving load deasserted afterwards.
    task automatic do_load(input logic [7:0] v);
        load       = 1'b1;
        load_value = v;
        step();
        load       = 1'b0;
    endtask

    // Pulse start for one edge (this is "edge 0" of the countdown).
    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        tests_run++;
        if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || tc !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: count=%0d busy=%b done=%b tc=%b, want 0 0 0 0", count, busy, done, tc);
        end
        rst = 1'b0;
        // start with no load: count=0 so the timer must stay idle
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || count !== 8'd0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: busy=%b count=%0d, want busy=0 count=0", busy, count);
        end
    endtask

    task automatic test_one_shot();
        logic [7:0] exp;
        auto_reload = 1'b0;
        do_load(8'd5);
        tests_run++;
        if (count !== 8'd5 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL oneshot_load: count=%0d busy=%b, want 5 0", count, busy);
        end
        do_start();
        tests_run++;
        if (count !== 8'd5 || busy !== 1'b1 || tc !== 1'b0) begin
            tests_failed++;
            $display("FAIL oneshot_edge0: count=%0d busy=%b tc=%b, want 5 1 0", count, busy, tc);
        end
        for (int i = 1; i <= 5; i++) begin
            step();
            exp = 8'(5 - i);
            tests_run++;
            if (count !== exp || tc !== (i == 5) || busy !== (i != 5) || done !== (i == 5)) begin
                tests_failed++;
                $display("FAIL oneshot_edge%0d: count=%0d tc=%b busy=%b done=%b, want %0d %b %b %b",
                         i, count, tc, busy, done, exp, (i == 5), (i != 5), (i == 5));
            end
        end
        step();
        tests_run++;
        if (tc !== 1'b0 || done !== 1'b1 || count !== 8'd0) begin
            tests_failed++;
            $display("FAIL oneshot_hold: tc=%b done=%b count=%0d, want 0 1 0", tc, done, count);
        end
    endtask

    task automatic test_periodic();
        logic [7:0] seq [8] = '{8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd3, 8'd2, 8'd1};
        logic       tcs [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        auto_reload = 1'b1;
        do_load(8'd3);
        do_start();
        for (int i = 0; i < 8; i++) begin
            step();
            tests_run++;
            if (count !== seq[i] || tc !== tcs[i] || done !== 1'b0 || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL periodic_edge%0d: count=%0d tc=%b done=%b busy=%b, want %0d %b 0 1",
                         i + 1, count, tc, done, busy, seq[i], tcs[i]);
            end
        end
        // reload value 1 in periodic mode: tc stays high every cycle
        do_load(8'd1);
        do_start();
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (tc !== 1'b1 || count !== 8'd1 || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL periodic_one_edge%0d: tc=%b count=%0d busy=%b, want 1 1 1", i + 1, tc, count, busy);
            end
        end
        auto_reload = 1'b0;
    endtask

    task automatic test_pause_resume();
        auto_reload = 1'b0;
        do_load(8'd10);
        do_start();
        for (int i = 0; i < 4; i++) step();  // 9,8,7,6
        stop = 1'b1;
        step();
        stop = 1'b0;
        tests_run++;
        if (count !== 8'd6 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL pause_enter: count=%0d busy=%b, want 6 0", count, busy);
        end
        for (int i = 0; i < 3; i++) step();
        tests_run++;
        if (count !== 8'd6 || busy !== 1'b0 || tc !== 1'b0) begin
            tests_failed++;
            $display("FAIL pause_hold: count=%0d busy=%b tc=%b, want 6 0 0", count, busy, tc);
        end
        do_start();
        tests_run++;
        if (count !== 8'd6 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL resume_edge0: count=%0d busy=%b, want 6 1", count, busy);
        end
        step();
        tests_run++;
        if (count !== 8'd5) begin
            tests_failed++;
            $display("FAIL resume_edge1: count=%0d, want 5", count);
        end
        stop  = 1'b1;
        start = 1'b1;
        step();
        stop  = 1'b0;
        start = 1'b0;
        tests_run++;
        if (count !== 8'd5 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL stop_beats_start: count=%0d busy=%b, want 5 0", count, busy);
        end
    endtask

    task automatic test_boundaries();
        auto_reload = 1'b0;
        // zero load: start ignored
        do_load(8'd0);
        do_start();
        step();
        tests_run++;
        if (busy !== 1'b0 || count !== 8'd0 || tc !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_start: busy=%b count=%0d tc=%b, want 0 0 0", busy, count, tc);
        end
        // load 1: terminal at edge 1
        do_load(8'd1);
        do_start();
        step();
        tests_run++;
        if (tc !== 1'b1 || done !== 1'b1 || count !== 8'd0) begin
            tests_failed++;
            $display("FAIL load_one: tc=%b done=%b count=%0d, want 1 1 0", tc, done, count);
        end
        // DONE then start: reload to 1 and run again
        do_start();
        tests_run++;
        if (count !== 8'd1 || busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_restart: count=%0d busy=%b done=%b, want 1 1 0", count, busy, done);
        end
        step();
        tests_run++;
        if (tc !== 1'b1 || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL done_restart_tc: tc=%b done=%b, want 1 1", tc, done);
        end
        // load during RUN
        do_load(8'd9);
        do_start();
        step();
        step();
        do_load(8'd4);
        tests_run++;
        if (count !== 8'd4 || busy !== 1'b0 || done !== 1'b0 || tc !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_in_run: count=%0d busy=%b done=%b tc=%b, want 4 0 0 0", count, busy, done, tc);
        end
    endtask

    task automatic test_reset_mid_run();
        auto_reload = 1'b0;
        do_load(8'd9);
        do_start();
        step();
        step();  // count 7
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (count !== 8'd0 || busy !== 1'b0 || tc !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: count=%0d busy=%b tc=%b, want 0 0 0", count, busy, tc);
        end
        step();
        rst = 1'b0;
        step();
        tests_run++;
        if (tc !== 1'b0 || busy !== 1'b0 || count !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_release: tc=%b busy=%b count=%0d, want 0 0 0", tc, busy, count);
        end
    endtask

`ifdef DOWN_TIMER_PRESCALE_EN
    task automatic test_prescale();
        logic [7:0] exp;
        logic       exp_tc;
        prescale    = 4'd2;
        auto_reload = 1'b0;
        do_load(8'd2);
        do_start();
        for (int i = 1; i <= 6; i++) begin
            step();
            exp    = (i >= 6) ? 8'd0 : (i >= 3) ? 8'd1 : 8'd2;
            exp_tc = (i == 6);
            tests_run++;
            if (count !== exp || tc !== exp_tc) begin
                tests_failed++;
                $display("FAIL prescale_edge%0d: count=%0d tc=%b, want %0d %b", i, count, tc, exp, exp_tc);
            end
        end
        prescale = 4'd0;
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        load         = 1'b0;
        load_value   = 8'd0;
        start        = 1'b0;
        stop         = 1'b0;
        auto_reload  = 1'b0;
`ifdef DOWN_TIMER_PRESCALE_EN
        prescale     = 4'd0;
`endif
        test_reset();
        test_one_shot();
        test_periodic();
        test_pause_resume();
        test_boundaries();
        test_reset_mid_run();
`ifdef DOWN_TIMER_PRESCALE_EN
        test_prescale();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
